// File: rtl/psum_accumulator.sv
// ----------------------------------------------------------------------------
// psum_accumulator
//   Accumulates LANES independent signed partial-sum lanes over a programmable
//   number of beats (one reduction group) and presents each finished group on
//   a one-deep registered output with a valid/ready handshake. Upstream is
//   back-pressured while a finished result is waiting and cannot be replaced.
//
// Optional feature macro: PSUM_ACC_SATURATE_EN
//   defined     : each lane add clamps to the signed ACC_WIDTH range, and the
//                 extra output sat_flag records (sticky) any clamp since reset
//   not defined : lane sums wrap modulo 2^ACC_WIDTH, no sat_flag port
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous reset, active-high
//   psum_valid psum_in carries a beat
//   psum_ready block accepts a beat this cycle
//   psum_in    lane i = psum_in[i*COL_WIDTH +: COL_WIDTH], signed
//   acc_len    beats per group, sampled on the first beat (0 is treated as 1)
//   out_valid  acc_out holds a finished group
//   out_ready  downstream takes acc_out
//   acc_out    lane i = acc_out[i*ACC_WIDTH +: ACC_WIDTH], signed
//   busy       high while a group is partially accumulated
//   sat_flag   (PSUM_ACC_SATURATE_EN only) sticky lane-clamp indicator
// ----------------------------------------------------------------------------
module psum_accumulator #(
    parameter int COL_WIDTH = 13,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 24,
    parameter int LEN_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         psum_valid,
    output logic                         psum_ready,
    input  logic [COL_WIDTH*LANES-1:0]   psum_in,
    input  logic [LEN_WIDTH-1:0]         acc_len,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_WIDTH*LANES-1:0]   acc_out,
    output logic                         busy
`ifdef PSUM_ACC_SATURATE_EN
    ,
    output logic                         sat_flag
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                               state_q, state_d;
    logic [LEN_WIDTH-1:0]                 cnt_q;
    logic [LEN_WIDTH-1:0]                 len_q;
    logic [LEN_WIDTH-1:0]                 eff_len;
    logic [LANES-1:0][ACC_WIDTH-1:0]      acc_q;
    logic [LANES-1:0][ACC_WIDTH-1:0]      sum_d;
    logic [LANES-1:0][ACC_WIDTH-1:0]      out_q;
    logic                                 out_valid_q;
    logic                                 beat_acc;
    logic                                 finish;
`ifdef PSUM_ACC_SATURATE_EN
    logic [LANES-1:0]                     clamp;
    logic                                 sat_q;
`endif

    // Stall only while a finished result is waiting and not being taken.
    assign psum_ready = !out_valid_q || out_ready;
    assign beat_acc   = psum_valid && psum_ready;
    assign eff_len    = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;

    assign out_valid  = out_valid_q;
    assign acc_out    = out_q;
    assign busy       = (state_q == ACCUM);
`ifdef PSUM_ACC_SATURATE_EN
    assign sat_flag   = sat_q;
`endif

    // ------------------------------------------------------------------
    // Per-lane add. In IDLE the base is zero, so the first beat of a
    // group (and a one-beat group) uses the same adder as later beats.
    // ------------------------------------------------------------------
    always_comb begin : lane_math
        logic signed [ACC_WIDTH-1:0] ext;
        logic signed [ACC_WIDTH-1:0] base;
`ifdef PSUM_ACC_SATURATE_EN
        logic signed [ACC_WIDTH:0]   wide;
        clamp = '0;
`endif
        sum_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            ext  = ACC_WIDTH'(signed'(psum_in[i*COL_WIDTH +: COL_WIDTH]));
            base = (state_q == ACCUM) ? acc_q[i] : '0;
`ifdef PSUM_ACC_SATURATE_EN
            wide = {base[ACC_WIDTH-1], base} + {ext[ACC_WIDTH-1], ext};
            // Overflow when the extra sign bit disagrees with the MSB.
            if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
                clamp[i] = 1'b1;
                sum_d[i] = wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                           : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end else begin
                sum_d[i] = wide[ACC_WIDTH-1:0];
            end
`else
            sum_d[i] = base + ext;
`endif
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and finish detection
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (beat_acc) begin
                    if (eff_len == LEN_WIDTH'(1)) begin
                        finish = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (beat_acc && (cnt_q == len_q - LEN_WIDTH'(1))) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            len_q       <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (beat_acc) begin
                if (state_q == IDLE) begin
                    len_q <= eff_len;
                end
                if (finish) begin
                    out_q <= sum_d;
                    acc_q <= '0;
                    cnt_q <= '0;
                end else begin
                    acc_q <= sum_d;
                    cnt_q <= cnt_q + LEN_WIDTH'(1);
                end
            end
            // A finish in the same cycle as a handshake keeps valid high.
            if (finish) begin
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef PSUM_ACC_SATURATE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (beat_acc && (|clamp)) begin
            sat_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_psum_accumulator.sv
module tb_psum_accumulator;

    localparam int CW = 13;
    localparam int L  = 4;
    localparam int AW = 24;
    localparam int LW = 8;
    localparam int AW14 = 14;

    logic               clk = 1'b0;
    logic               rst;
    logic               psum_valid;
    logic               psum_ready;
    logic [CW*L-1:0]    psum_in;
    logic [LW-1:0]      acc_len;
    logic               out_valid;
    logic               out_ready;
    logic [AW*L-1:0]    acc_out;
    logic               busy;

    logic               p14_valid;
    logic               p14_ready;
    logic [CW*L-1:0]    p14_in;
    logic [LW-1:0]      p14_len;
    logic               o14_valid;
    logic               o14_ready;
    logic [AW14*L-1:0]  o14_out;
    logic               busy14;
`ifdef PSUM_ACC_SATURATE_EN
    logic               sat_flag;
    logic               sat14;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    psum_accumulator #(.COL_WIDTH(CW), .LANES(L), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .psum_valid(psum_valid), .psum_ready(psum_ready),
        .psum_in(psum_in), .acc_len(acc_len), .out_valid(out_valid),
        .out_ready(out_ready), .acc_out(acc_out), .busy(busy)
`ifdef PSUM_ACC_SATURATE_EN
        , .sat_flag(sat_flag)
`endif
    );

    psum_accumulator #(.COL_WIDTH(CW), .LANES(L), .ACC_WIDTH(AW14), .LEN_WIDTH(LW)) dut14 (
        .clk(clk), .rst(rst), .psum_valid(p14_valid), .psum_ready(p14_ready),
        .psum_in(p14_in), .acc_len(p14_len), .out_valid(o14_valid),
        .out_ready(o14_ready), .acc_out(o14_out), .busy(busy14)
`ifdef PSUM_ACC_SATURATE_EN
        , .sat_flag(sat14)
`endif
    );

    function automatic logic [CW*L-1:0] pin(input int a, input int b, input int c, input int d);
        return {CW'(d), CW'(c), CW'(b), CW'(a)};
    endfunction

    function automatic logic [AW*L-1:0] pk(input int a, input int b, input int c, input int d);
        return {AW'(d), AW'(c), AW'(b), AW'(a)};
    endfunction

    // Drives one beat and returns right after the rising edge that accepts it.
    task automatic send_beat(input logic [CW*L-1:0] d, input logic [LW-1:0] len);
        int n;
        @(negedge clk);
        psum_valid = 1'b1;
        psum_in    = d;
        acc_len    = len;
        n = 0;
        while (!psum_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 50) begin
            fails++;
            $display("FAIL send_timeout: psum_ready=%0b required 1 within 50 cycles", psum_ready);
        end
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        psum_valid = 1'b0; psum_in = '0; acc_len = '0; out_ready = 1'b1;
        p14_valid = 1'b0; p14_in = '0; p14_len = '0; o14_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({out_valid, busy, psum_ready} !== 3'b001 || acc_out !== '0) begin
            fails++;
            $display("FAIL reset_state: valid/busy/ready=%b acc_out=%h required 001 / 0",
                     {out_valid, busy, psum_ready}, acc_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_accumulate;
        out_ready = 1'b1;
        send_beat(pin(1, 2, 3, 4), 8'd4);
        #1;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL accum_busy: busy=%b required 1", busy);
        end
        for (int i = 0; i < 3; i++) send_beat(pin(1, 2, 3, 4), 8'd9);
        @(negedge clk);
        psum_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || acc_out !== pk(4, 8, 12, 16) || busy !== 1'b0) begin
            fails++;
            $display("FAIL accum_result: valid=%b busy=%b acc_out=%h required 1 0 %h",
                     out_valid, busy, acc_out, pk(4, 8, 12, 16));
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL accum_pulse: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_single_beat;
        for (int k = 0; k < 2; k++) begin
            send_beat(pin(-5, 7, 0, -1), LW'(k));
            #1;
            tests++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL single_busy len=%0d: busy=%b required 0", k, busy);
            end
            @(negedge clk);
            psum_valid = 1'b0;
            tests++;
            if (out_valid !== 1'b1 || acc_out !== pk(-5, 7, 0, -1)) begin
                fails++;
                $display("FAIL single_result len=%0d: valid=%b acc_out=%h required 1 %h",
                         k, out_valid, acc_out, pk(-5, 7, 0, -1));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall;
        out_ready = 1'b1;
        send_beat(pin(1, 1, 1, 1), 8'd2);
        send_beat(pin(2, 2, 2, 2), 8'd2);
        @(negedge clk);
        psum_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || acc_out !== pk(3, 3, 3, 3)) begin
            fails++;
            $display("FAIL stall_group1: valid=%b acc_out=%h required 1 %h",
                     out_valid, acc_out, pk(3, 3, 3, 3));
        end
        @(negedge clk);
        out_ready = 1'b0;
        send_beat(pin(10, 20, 30, 40), 8'd2);
        send_beat(pin(1, 2, 3, 4), 8'd2);
        @(negedge clk);
        psum_in = pin(100, 0, 0, 0);
        acc_len = 8'd2;
        tests++;
        if (out_valid !== 1'b1 || psum_ready !== 1'b0 || acc_out !== pk(11, 22, 33, 44)) begin
            fails++;
            $display("FAIL stall_group2: valid=%b ready=%b acc_out=%h required 1 0 %h",
                     out_valid, psum_ready, acc_out, pk(11, 22, 33, 44));
        end
        repeat (3) @(negedge clk);
        tests++;
        if (psum_ready !== 1'b0 || busy !== 1'b0 || acc_out !== pk(11, 22, 33, 44)) begin
            fails++;
            $display("FAIL stall_hold: ready=%b busy=%b acc_out=%h required 0 0 %h",
                     psum_ready, busy, acc_out, pk(11, 22, 33, 44));
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (psum_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_release_ready: psum_ready=%b required 1", psum_ready);
        end
        @(posedge clk);
        @(negedge clk);
        psum_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL stall_release: valid=%b busy=%b required 0 1", out_valid, busy);
        end
        send_beat(pin(5, 6, 7, 8), 8'd2);
        @(negedge clk);
        psum_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || acc_out !== pk(105, 6, 7, 8)) begin
            fails++;
            $display("FAIL stall_group3: valid=%b acc_out=%h required 1 %h",
                     out_valid, acc_out, pk(105, 6, 7, 8));
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            psum_valid = 1'b1;
            psum_in    = pin(k, k, k, k);
            acc_len    = 8'd1;
            if (k > 1) begin
                tests++;
                if (out_valid !== 1'b1 || acc_out !== pk(k-1, k-1, k-1, k-1)) begin
                    fails++;
                    $display("FAIL b2b_len1 k=%0d: valid=%b acc_out=%h required 1 %h",
                             k, out_valid, acc_out, pk(k-1, k-1, k-1, k-1));
                end
            end
            @(posedge clk);
        end
        send_beat(pin(1, -1, 2, -2), 8'd2);
        send_beat(pin(2, -2, 3, -3), 8'd2);
        #1;
        tests++;
        if (out_valid !== 1'b1 || acc_out !== pk(3, -3, 5, -5)) begin
            fails++;
            $display("FAIL b2b_len2_g1: valid=%b acc_out=%h required 1 %h",
                     out_valid, acc_out, pk(3, -3, 5, -5));
        end
        send_beat(pin(-100, 50, 0, 7), 8'd2);
        send_beat(pin(-1, 50, 9, 7), 8'd2);
        #1;
        tests++;
        if (out_valid !== 1'b1 || acc_out !== pk(-101, 100, 9, 14)) begin
            fails++;
            $display("FAIL b2b_len2_g2: valid=%b acc_out=%h required 1 %h",
                     out_valid, acc_out, pk(-101, 100, 9, 14));
        end
        @(negedge clk);
        psum_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        out_ready = 1'b0;
        send_beat(pin(9, 9, 9, 9), 8'd1);
        @(negedge clk);
        psum_valid = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || acc_out !== '0) begin
            fails++;
            $display("FAIL reset_outvalid: valid=%b acc_out=%h required 0 0", out_valid, acc_out);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send_beat(pin(7, 7, 7, 7), 8'd4);
        send_beat(pin(7, 7, 7, 7), 8'd4);
        @(negedge clk);
        psum_valid = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || acc_out !== '0) begin
            fails++;
            $display("FAIL reset_midgroup: busy=%b valid=%b acc_out=%h required 0 0 0",
                     busy, out_valid, acc_out);
        end
        @(negedge clk);
        rst = 1'b0;
        send_beat(pin(1, 1, 1, 1), 8'd2);
        send_beat(pin(1, 1, 1, 1), 8'd2);
        @(negedge clk);
        psum_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || acc_out !== pk(2, 2, 2, 2)) begin
            fails++;
            $display("FAIL reset_next_group: valid=%b acc_out=%h required 1 %h",
                     out_valid, acc_out, pk(2, 2, 2, 2));
        end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        logic signed [AW14-1:0] lane0;
        int exp;
`ifdef PSUM_ACC_SATURATE_EN
        exp = 8191;
`else
        exp = -4099;
`endif
        o14_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            p14_valid = 1'b1;
            p14_in    = pin(4095, 0, 0, 0);
            p14_len   = 8'd3;
            tests++;
            if (p14_ready !== 1'b1) begin
                fails++;
                $display("FAIL wrap_ready k=%0d: psum_ready=%b required 1", k, p14_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        p14_valid = 1'b0;
        lane0 = o14_out[AW14-1:0];
        tests++;
        if (o14_valid !== 1'b1 || lane0 !== AW14'(exp) || o14_out[AW14*L-1:AW14] !== '0) begin
            fails++;
            $display("FAIL wrap_result: valid=%b lane0=%0d upper=%h required 1 %0d 0",
                     o14_valid, lane0, o14_out[AW14*L-1:AW14], exp);
        end
`ifdef PSUM_ACC_SATURATE_EN
        tests++;
        if (sat14 !== 1'b1 || sat_flag !== 1'b0) begin
            fails++;
            $display("FAIL sat_flag: sat14=%b sat_main=%b required 1 0", sat14, sat_flag);
        end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_single_beat();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
